// File: rtl/exp8_pkg.sv
// Shared types for the counter/decoder self-check stage: FSM state encoding and fault codes.
package exp8_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_DEC  = 2'b01;
  localparam logic [1:0] FC_STEP = 2'b10;
  localparam logic [1:0] FC_BOTH = 2'b11;

endpackage

// File: rtl/onehot_match.sv
// Flags any decoder pattern that is not the exact one-hot image of the count,
// including all-zero and multi-hot patterns.
module onehot_match #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0]        counter_out,
  input  logic [(2**CNT_W)-1:0]   decoder_out,
  output logic                    dec_err_c
);

  localparam int unsigned DEC_W = 2 ** CNT_W;

  logic [DEC_W-1:0] expected_c;

  assign expected_c = DEC_W'(1) << counter_out;
  assign dec_err_c  = (decoder_out != expected_c);

endmodule

// File: rtl/phase_sequence_checker.sv
// Locks onto the upstream count at 0, tracks legal hold/+1 steps, counts wraps
// and latches a sticky fault code until acknowledged.
module phase_sequence_checker
  import exp8_pkg::*;
#(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned CYCLE_W = 8
) (
  input  logic                    clockpulse,
  input  logic                    clear,
  input  logic [CNT_W-1:0]        counter_out,
  input  logic [(2**CNT_W)-1:0]   decoder_out,
  input  logic                    ack_fault,
  output logic                    locked,
  output logic [CYCLE_W-1:0]      cycle_count,
  output logic                    fault,
  output logic [1:0]              fault_code
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   prev_inc_c;
  logic               locked_d, fault_d;
  logic [CYCLE_W-1:0] cycle_d;
  logic [1:0]         code_d;
  logic               dec_err_c, step_err_c, wrap_c;

  onehot_match #(.CNT_W(CNT_W)) u_onehot_match (
    .counter_out (counter_out),
    .decoder_out (decoder_out),
    .dec_err_c   (dec_err_c)
  );

  // Step legality and wrap detection against the last tracked count.
  assign prev_inc_c = prev_q + CNT_W'(1);
  assign step_err_c = (counter_out != prev_q) && (counter_out != prev_inc_c);
  assign wrap_c     = (prev_q == '1) && (counter_out == '0);

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      locked      <= 1'b0;
      cycle_count <= '0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      locked      <= locked_d;
      cycle_count <= cycle_d;
      fault       <= fault_d;
      fault_code  <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    locked_d = locked;
    cycle_d  = cycle_count;
    fault_d  = fault;
    code_d   = fault_code;
    case (state_q)
      SYNC: begin
        if (dec_err_c) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          code_d   = FC_DEC;
          locked_d = 1'b0;
        end else if (counter_out == '0) begin
          state_d  = TRACK;
          prev_d   = '0;
          locked_d = 1'b1;
        end
      end
      TRACK: begin
        if (dec_err_c || step_err_c) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          code_d   = {step_err_c, dec_err_c};
          locked_d = 1'b0;
        end else begin
          prev_d = counter_out;
          // Saturate rather than roll over so a long run never reads as few wraps.
          if (wrap_c && (cycle_count != '1)) begin
            cycle_d = cycle_count + CYCLE_W'(1);
          end
        end
      end
      FAULT: begin
        if (ack_fault) begin
          state_d = SYNC;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d  = SYNC;
        locked_d = 1'b0;
        fault_d  = 1'b0;
        code_d   = FC_NONE;
      end
    endcase
  end

endmodule

// File: doc/phase_sequence_checker.md
Name: phase_sequence_checker

Overview:
- Downstream consumer of the 2-bit counter / 2-to-4 decoder stage. It samples `counter_out` and `decoder_out` on every clock.
- It verifies that the decoder output is the one-hot image of the count, and that the count only holds or advances by +1 mod 4.
- It counts completed 0->1->2->3->0 cycles and latches a sticky fault with a code until acknowledged.
- Used as the self-check / display-feed stage behind the counter-decoder pair in the lab top level.

Parameters:
- CNT_W, 2, counter width; decoder width DEC_W = 2**CNT_W is derived, not a parameter.
- CYCLE_W, 8, width of the completed-cycle counter.

Ports:
- clockpulse  input  1  clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- counter_out  input  CNT_W  count from the upstream counter.
- decoder_out  input  DEC_W  one-hot output from the upstream decoder.
- ack_fault  input  1  single-cycle pulse; releases FAULT.
- locked  output  1  high while in TRACK.
- cycle_count  output  CYCLE_W  number of completed wraps (max -> 0).
- fault  output  1  high while in FAULT.
- fault_code  output  2  cause of fault: 01 decode mismatch, 10 illegal step, 11 both; 00 when no fault.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous, active-high: `clear` sampled high at a rising edge of `clockpulse` resets all state.
  - Reset values: state = SYNC, locked = 0, cycle_count = 0, fault = 0, fault_code = 00, prev_q = 0.
- Outputs are registered; every response appears 1 cycle after the sampled inputs.
- Combinational checks on the current inputs:
  - dec_err = (decoder_out != 1 << counter_out), including all-zero and multi-hot patterns.
  - step_err = (counter_out != prev_q) && (counter_out != prev_q + 1 mod 2**CNT_W).
  - wrap = (prev_q == 2**CNT_W - 1) && (counter_out == 0).
- State SYNC:
  - dec_err -> FAULT with code 01.
  - counter_out == 0 and no dec_err -> TRACK; set prev_q <= 0 and locked <= 1.
  - Otherwise stay in SYNC. step_err is ignored in SYNC.
- State TRACK:
  - Any of dec_err / step_err -> FAULT with code {step_err, dec_err}; locked <= 0.
  - Otherwise update prev_q <= counter_out.
  - On wrap, cycle_count increments and saturates at 2**CYCLE_W - 1 (no roll-over).
  - A held count (no change) is legal and counts nothing.
- State FAULT:
  - fault = 1; fault_code and cycle_count are frozen; the inputs are ignored.
  - ack_fault = 1 -> SYNC; fault <= 0, fault_code <= 00; cycle_count is kept.
- Priority:
  - clear beats ack_fault and all checks.
  - ack_fault in SYNC or TRACK has no effect.
- clear mid-cycle (any state) fully restarts the block: cycle_count is zeroed and the checker must re-lock at count 0.
- The first cycle after reset is SYNC, so an upstream counter still held at 0 by its own clear locks immediately.

Decomposition:
- Shared package exp8_pkg:
  - state encoding SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2;
  - fault codes FC_NONE = 2'b00, FC_DEC = 2'b01, FC_STEP = 2'b10, FC_BOTH = 2'b11.
- One natural sub-module: onehot_match, a combinational comparator that takes counter_out and decoder_out and returns dec_err, parameterised by CNT_W.
- The FSM, prev_q register and saturating counter stay in phase_sequence_checker.

Test Plan:
- Clean run:
  - Stimulus: clear = 1 for 1 cycle, then drive counter 0,1,2,3 repeated 3 full times with matching one-hot 0001,0010,0100,1000.
  - Required: locked = 1 one cycle after the first 0; cycle_count = 3 after the third 3->0; fault = 0 throughout.
- Hold tolerance:
  - Stimulus: sequence 0,0,1,1,1,2,3,3,0.
  - Required: no fault; cycle_count increments by exactly 1.
- Decode mismatch:
  - Stimulus: in TRACK, drive counter = 2 with decoder = 0010.
  - Required: next cycle fault = 1, fault_code = 01, locked = 0; cycle_count frozen.
  - Then pulse ack_fault: SYNC, re-lock on the next 0.
- Illegal step plus both:
  - Stimulus 1: 0,1,3 with correct decode.
  - Required 1: fault_code = 10.
  - Stimulus 2: after ack and re-lock, drive 1->3 with decoder = 0000.
  - Required 2: fault_code = 11.
- Saturation and reset:
  - Stimulus: preload via 2**CYCLE_W + 2 wraps.
  - Required: cycle_count stays 255.
  - Then assert clear while in TRACK: next cycle cycle_count = 0, locked = 0; clear and ack_fault together yield reset values.
